// File: rtl/skew_feeder_pkg.sv
// Shared configuration for the systolic input feeder: array geometry defaults
// and the feeder sequencing state type.
package skew_feeder_pkg;

    localparam int sys_rows           = 4;
    localparam int A_BITWIDTH         = 8;
    localparam int input_buffer_depth = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/skew_feeder_sync.sv
// Single-clock FIFO for one feeder row: combinational head word, registered
// full/empty flags, and a push that is still accepted when full if a pop frees a slot.
module sync_fifo #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DWIDTH-1:0]      wdata,
    output logic [DWIDTH-1:0]      rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [AW:0]       count_next;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + (AW + 1)'(1);
        end else if (do_pop && !do_push) begin
            count_next = count - (AW + 1)'(1);
        end
    end

    // Flags are registered from the next count so they never lag the pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            count <= count_next;
            full  <= (count_next == FULL_CNT);
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wptr] <= wdata;
        end
    end

endmodule

// File: rtl/skew_feeder.sv
// Row FIFOs feeding a systolic array: a burst of len vectors is read out with
// row i lagging row 0 by i cycles (diagonal skew) or with all rows aligned.
module skew_feeder
    import skew_feeder_pkg::*;
#(
    parameter int ROWS   = sys_rows,
    parameter int DWIDTH = A_BITWIDTH,
    parameter int DEPTH  = input_buffer_depth,
    parameter int LEN_W  = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ROWS-1:0]        wr_en,
    input  logic [ROWS*DWIDTH-1:0] wr_data,
    output logic [ROWS-1:0]        full,
    output logic [ROWS-1:0]        empty,
    input  logic                   skew_en,
    input  logic                   start,
    input  logic [LEN_W-1:0]       len,
    input  logic                   stall,
    output logic                   busy,
    output logic                   done,
    output logic [ROWS-1:0]        o_valid,
    output logic [ROWS*DWIDTH-1:0] o_data,
    output logic                   ovf,
    output logic                   udf
);

    localparam int CW = $clog2(DEPTH) + 1;

    feeder_state_t    state;
    feeder_state_t    state_next;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_first;
    logic [LEN_W-1:0] cnt_last;
    logic             skew_q;
    logic             skew_sel;
    logic             accept;
    logic             first_last;
    logic             last_last;
    logic [ROWS-1:0]  sched;
    logic [ROWS-1:0]  sched_next;
    logic [ROWS-1:0]  pop_req;
    logic [ROWS-1:0]  pop_ok;
    logic [ROWS-1:0]  push_drop;
    logic [DWIDTH-1:0] head [ROWS];
    logic [CW-1:0]     count [ROWS];

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        sync_fifo #(
            .DWIDTH (DWIDTH),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (wr_en[r]),
            .pop   (pop_req[r]),
            .wdata (wr_data[r*DWIDTH +: DWIDTH]),
            .rdata (head[r]),
            .full  (full[r]),
            .empty (empty[r]),
            .count (count[r])
        );

        assign pop_ok[r]    = pop_req[r] && (count[r] != '0);
        assign push_drop[r] = wr_en[r] && full[r] && !pop_ok[r];
    end

    assign busy       = (state != IDLE);
    assign pop_req    = sched & {ROWS{!stall}};
    assign skew_sel   = accept ? skew_en : skew_q;
    assign first_last = pop_req[0] && (cnt_first == len_q - LEN_W'(1));
    assign last_last  = pop_req[ROWS-1] && (cnt_last == len_q - LEN_W'(1));

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        if (!stall) begin
            unique case (state)
                IDLE: begin
                    if (start && (len != '0)) begin
                        state_next = RUN;
                        accept     = 1'b1;
                    end
                end
                RUN: begin
                    if (first_last) begin
                        state_next = (skew_q && (ROWS > 1)) ? DRAIN : IDLE;
                    end
                end
                DRAIN: begin
                    if (last_last) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // sched[i] is row i's pop enable for the current cycle; row 0 follows RUN,
    // the others take their upper neighbour's previous enable when skewing.
    always_comb begin
        sched_next = sched;
        if (!stall) begin
            sched_next[0] = (state_next == RUN);
            for (int i = 1; i < ROWS; i++) begin
                sched_next[i] = skew_sel ? sched[i-1] : (state_next == RUN);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sched     <= '0;
            len_q     <= '0;
            skew_q    <= 1'b0;
            cnt_first <= '0;
            cnt_last  <= '0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            udf       <= 1'b0;
            o_valid   <= '0;
            o_data    <= '0;
        end else begin
            state <= state_next;
            sched <= sched_next;
            done  <= (state != IDLE) && (state_next == IDLE);
            if (accept) begin
                len_q     <= len;
                skew_q    <= skew_en;
                cnt_first <= '0;
                cnt_last  <= '0;
            end else begin
                if (pop_req[0]) begin
                    cnt_first <= cnt_first + LEN_W'(1);
                end
                if (pop_req[ROWS-1]) begin
                    cnt_last <= cnt_last + LEN_W'(1);
                end
            end
            if (|(pop_req & ~pop_ok)) begin
                udf <= 1'b1;
            end
            if (|push_drop) begin
                ovf <= 1'b1;
            end
            o_valid <= pop_ok;
            for (int r = 0; r < ROWS; r++) begin
                if (pop_ok[r]) begin
                    o_data[r*DWIDTH +: DWIDTH] <= head[r];
                end
            end
        end
    end

endmodule

// File: tb/tb_skew_feeder.sv
// Scoreboard bench for skew_feeder: a slot-based reference model queues the
// expected outputs of every edge and a negedge monitor compares them.
module tb_skew_feeder;

    localparam int ROWS  = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 64;
    localparam int LEN_W = 7;

    logic                clk = 1'b0;
    logic                rst;
    logic [ROWS-1:0]     wr_en;
    logic [ROWS*DW-1:0]  wr_data;
    logic [ROWS-1:0]     full;
    logic [ROWS-1:0]     empty;
    logic                skew_en;
    logic                start;
    logic [LEN_W-1:0]    len;
    logic                stall;
    logic                busy;
    logic                done;
    logic [ROWS-1:0]     o_valid;
    logic [ROWS*DW-1:0]  o_data;
    logic                ovf;
    logic                udf;

    always #5 clk = ~clk;

    skew_feeder #(
        .ROWS   (ROWS),
        .DWIDTH (DW),
        .DEPTH  (DEPTH),
        .LEN_W  (LEN_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .empty   (empty),
        .skew_en (skew_en),
        .start   (start),
        .len     (len),
        .stall   (stall),
        .busy    (busy),
        .done    (done),
        .o_valid (o_valid),
        .o_data  (o_data),
        .ovf     (ovf),
        .udf     (udf)
    );

    typedef struct packed {
        logic [ROWS-1:0]    valid;
        logic [ROWS*DW-1:0] data;
        logic               done;
        logic               busy;
        logic               ovf;
        logic               udf;
        logic [ROWS-1:0]    full;
        logic [ROWS-1:0]    empty;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   passes = 0;

    logic [DW-1:0]      mfifo [ROWS][$];
    logic [ROWS*DW-1:0] m_data;
    bit                 m_busy;
    bit                 m_skew;
    bit                 m_ovf;
    bit                 m_udf;
    int                 m_len;
    int                 m_slot;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a burst is a count of non-stalled slots since start;
    // row r pops in slots delay+1 .. delay+len, delay = r when skewing.
    always @(posedge clk) begin
        exp_t            e;
        logic [ROWS-1:0] popped;
        int              d;
        e      = '0;
        popped = '0;
        if (rst) begin
            for (int r = 0; r < ROWS; r++) mfifo[r].delete();
            m_busy = 0;
            m_ovf  = 0;
            m_udf  = 0;
            m_data = '0;
        end else begin
            if (m_busy && !stall) begin
                m_slot++;
                for (int r = 0; r < ROWS; r++) begin
                    d = m_skew ? r : 0;
                    if (m_slot > d && m_slot <= m_len + d) begin
                        if (mfifo[r].size() > 0) begin
                            popped[r] = 1'b1;
                            m_data[r*DW +: DW] = mfifo[r].pop_front();
                        end else begin
                            m_udf = 1;
                        end
                    end
                end
                if (m_slot == m_len + (m_skew ? ROWS - 1 : 0)) begin
                    m_busy = 0;
                    e.done = 1'b1;
                end
            end else if (!m_busy && !stall && start && len != 0) begin
                m_busy = 1;
                m_skew = skew_en;
                m_len  = int'(len);
                m_slot = 0;
            end
            for (int r = 0; r < ROWS; r++) begin
                if (wr_en[r]) begin
                    if (mfifo[r].size() < DEPTH) mfifo[r].push_back(wr_data[r*DW +: DW]);
                    else m_ovf = 1;
                end
            end
        end
        e.valid = popped;
        e.data  = m_data;
        e.busy  = m_busy;
        e.ovf   = m_ovf;
        e.udf   = m_udf;
        for (int r = 0; r < ROWS; r++) begin
            e.full[r]  = (mfifo[r].size() == DEPTH);
            e.empty[r] = (mfifo[r].size() == 0);
        end
        expq.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            checkOutput("o_valid", 64'(o_valid), 64'(e.valid));
            checkOutput("o_data",  64'(o_data),  64'(e.data));
            checkOutput("done",    64'(done),    64'(e.done));
            checkOutput("busy",    64'(busy),    64'(e.busy));
            checkOutput("ovf",     64'(ovf),     64'(e.ovf));
            checkOutput("udf",     64'(udf),     64'(e.udf));
            checkOutput("full",    64'(full),    64'(e.full));
            checkOutput("empty",   64'(empty),   64'(e.empty));
        end
    end

    task automatic applyStimulus(input logic [ROWS-1:0] we, input logic [ROWS*DW-1:0] wd,
                                 input logic st, input logic [LEN_W-1:0] ln, input logic sk,
                                 input logic stl, input logic rs);
        wr_en   = we;
        wr_data = wd;
        start   = st;
        len     = ln;
        skew_en = sk;
        stall   = stl;
        rst     = rs;
        @(negedge clk);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus('0, '0, 0, '0, 0, 0, 0);
    endtask

    task automatic resetDut();
        applyStimulus('0, '0, 0, '0, 0, 0, 1);
        applyStimulus('0, '0, 0, '0, 0, 0, 1);
        idleCycles(1);
    endtask

    task automatic preload(input logic [ROWS-1:0] mask2);
        logic [ROWS*DW-1:0] wd;
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < ROWS; r++) wd[r*DW +: DW] = DW'(10 * r + k);
            applyStimulus((k < 2) ? {ROWS{1'b1}} : mask2, wd, 0, '0, 0, 0, 0);
        end
    endtask

    task automatic waitIdle(input int maxCycles);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < maxCycles) begin
            idleCycles(1);
            n++;
        end
        checkOutput("burst_finished", 64'(busy), 64'(0));
        idleCycles(2);
    endtask

    initial begin
        logic [ROWS-1:0]    we;
        logic [ROWS*DW-1:0] wd;
        wr_en = '0; wr_data = '0; start = 0; len = '0; skew_en = 0; stall = 0; rst = 1;
        @(negedge clk);
        resetDut();

        $display("[TB] skewed burst");
        preload('1);
        applyStimulus('0, '0, 1, 7'd4, 1, 0, 0);
        waitIdle(20);

        $display("[TB] aligned burst");
        preload('1);
        applyStimulus('0, '0, 1, 7'd4, 0, 0, 0);
        waitIdle(20);

        $display("[TB] stall mid-burst");
        preload('1);
        applyStimulus('0, '0, 1, 7'd4, 1, 0, 0);
        idleCycles(2);
        applyStimulus('0, '0, 0, '0, 0, 1, 0);
        applyStimulus('0, '0, 1, 7'd2, 0, 1, 0);
        waitIdle(20);

        $display("[TB] short row underflow");
        preload(4'b1011);
        applyStimulus('0, '0, 1, 7'd4, 1, 0, 0);
        waitIdle(20);
        resetDut();

        $display("[TB] overflow and full push+pop");
        for (int k = 0; k <= DEPTH; k++) applyStimulus(4'b0001, (ROWS*DW)'(k), 0, '0, 0, 0, 0);
        applyStimulus('0, '0, 1, 7'd64, 0, 0, 0);
        applyStimulus(4'b0001, (ROWS*DW)'(8'hAA), 0, '0, 0, 0, 0);
        waitIdle(100);
        applyStimulus('0, '0, 1, 7'd1, 0, 0, 0);
        waitIdle(10);
        resetDut();

        $display("[TB] reset mid-burst");
        preload('1);
        applyStimulus('0, '0, 1, 7'd4, 1, 0, 0);
        idleCycles(2);
        applyStimulus('1, '1, 1, 7'd3, 1, 1, 1);
        idleCycles(2);
        preload('1);
        applyStimulus('0, '0, 1, 7'd4, 1, 0, 0);
        applyStimulus('0, '0, 1, 7'd2, 0, 0, 0);
        waitIdle(20);
        applyStimulus('0, '0, 1, 7'd0, 1, 0, 0);
        idleCycles(3);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 1500; i++) begin
            for (int r = 0; r < ROWS; r++) begin
                we[r] = ($urandom_range(0, 2) == 0);
                wd[r*DW +: DW] = DW'($urandom);
            end
            applyStimulus(we, wd, ($urandom_range(0, 7) == 0), LEN_W'($urandom_range(0, 10)),
                          1'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 299) == 0));
        end
        waitIdle(200);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
